// File: rtl/f36m_mult.sv
// GF(3^{6M}) multiplier, GF(3^{6M}) = GF(3^{3M})[sigma]/(sigma^2+1).
//
// Field tower used throughout (M = 5):
//   GF(3^M)   = GF(3)[y]/(y^5 - y - 2)            (y^5 = y + 2)
//   GF(3^{3M}) = GF(3^M)[rho]/(rho^3 - rho - 1)   (rho^3 = rho + 1)
//   GF(3^{6M}) = GF(3^{3M})[sigma]/(sigma^2 + 1)
// A GF(3) trit is 2 bits (00=0, 01=1, 10=2). A GF(3^M) element is 5 trits,
// trit i = coefficient of y^i. A GF(3^{3M}) element is {e2,e1,e0}, e_i the
// coefficient of rho^i. A GF(3^{6M}) element is {x1,x0} = x0 + x1*sigma.
//
// Modules in this file:
//   gf3_add    one-trit adder (per-trit lane cell)
//   f33m_add   GF(3^{3M}) add,      ports a, b -> c
//   f33m_sub   GF(3^{3M}) subtract, ports a, b -> c = a - b
//   f33m_mult  GF(3^{3M}) sequential multiplier
//              clk, reset (sync, high, doubles as start), a, b -> c, done
//   f36m_mult  top: clk, reset (sync, high, start), a, b -> c, done

`ifndef F36M_WIDTHS
`define F36M_WIDTHS
`define F3M 5
`define W3 (2*3*`F3M-1)
`define W6 (2*(`W3+1)-1)
`endif

module gf3_add (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] c
);
  logic [2:0] s;
  assign s = {1'b0, a} + {1'b0, b};
  assign c = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
endmodule

module f33m_add (
  input  logic [`W3:0] a,
  input  logic [`W3:0] b,
  output logic [`W3:0] c
);
  localparam int NUM_TRITS = (`W3 + 1) / 2;
  for (genvar i = 0; i < NUM_TRITS; i++) begin : g_trit
    gf3_add u_add (.a(a[2*i +: 2]), .b(b[2*i +: 2]), .c(c[2*i +: 2]));
  end
endmodule

module f33m_sub (
  input  logic [`W3:0] a,
  input  logic [`W3:0] b,
  output logic [`W3:0] c
);
  localparam int NUM_TRITS = (`W3 + 1) / 2;
  for (genvar i = 0; i < NUM_TRITS; i++) begin : g_trit
    // -b in this encoding is a bit swap: 01 <-> 10, 00 stays 00.
    gf3_add u_add (.a(a[2*i +: 2]), .b({b[2*i], b[2*i+1]}), .c(c[2*i +: 2]));
  end
endmodule

// Horner over rho: acc = acc*rho + a_k*b for k = 2,1,0, one digit per cycle.
// done rises on the 3rd edge after reset is released and holds until reset.
module f33m_mult (
  input  logic        clk,
  input  logic        reset,
  input  logic [`W3:0] a,
  input  logic [`W3:0] b,
  output logic [`W3:0] c,
  output logic        done
);
  localparam int TW = (`W3 + 1) / 3;  // bits per GF(3^M) coefficient
  localparam int MT = TW / 2;         // trits per GF(3^M) coefficient
  typedef logic [TW-1:0] fm_t;

  function automatic logic [1:0] t_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [1:0] t_mul(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] r;
    case (x)
      2'd1:    r = y;
      2'd2:    r = {y[0], y[1]};
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic fm_t fm_add(input fm_t x, input fm_t y);
    fm_t r;
    for (int j = 0; j < MT; j++) r[2*j +: 2] = t_add(x[2*j +: 2], y[2*j +: 2]);
    return r;
  endfunction

  // Horner over y inside GF(3^M); the trit pushed past y^4 folds back as y + 2.
  function automatic fm_t fm_mul(input fm_t x, input fm_t y);
    fm_t r, sh, sc;
    r = '0;
    for (int i = MT - 1; i >= 0; i--) begin
      sh       = {r[TW-3:0], 2'b00};
      sh[1:0]  = t_mul(2'd2, r[TW-1 -: 2]);
      sh[3:2]  = t_add(sh[3:2], r[TW-1 -: 2]);
      for (int j = 0; j < MT; j++) sc[2*j +: 2] = t_mul(x[2*i +: 2], y[2*j +: 2]);
      r = fm_add(sh, sc);
    end
    return r;
  endfunction

  fm_t [2:0] av, bv, acc, nxt;
  fm_t       a_dig;
  logic [1:0] cnt;

  assign av = a;
  assign bv = b;
  assign c  = acc;

  always_comb begin
    case (cnt)
      2'd0:    a_dig = av[2];
      2'd1:    a_dig = av[1];
      default: a_dig = av[0];
    endcase
    // acc*rho with rho^3 = rho + 1
    nxt[0] = acc[2];
    nxt[1] = fm_add(acc[0], acc[2]);
    nxt[2] = acc[1];
    for (int k = 0; k < 3; k++) nxt[k] = fm_add(nxt[k], fm_mul(a_dig, bv[k]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      cnt  <= 2'd0;
      done <= 1'b0;
    end else if (!done) begin
      acc <= nxt;
      cnt <= cnt + 2'd1;
      if (cnt == 2'd2) done <= 1'b1;
    end
  end
endmodule

// Karatsuba with one shared f33m_mult:
//   t0 = a0*b0, t1 = a1*b1, t2 = (a0+a1)*(b0+b1)
//   c0 = t0 - t1 (sigma^2 = -1), c1 = t2 - t0 - t1
module f36m_mult (
  input  logic        clk,
  input  logic        reset,
  input  logic [`W6:0] a,
  input  logic [`W6:0] b,
  output logic [`W6:0] c,
  output logic        done
);
  typedef enum logic [2:0] {ISS0, WT0, ISS1, WT1, ISS2, WT2, FIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [`W3:0] a0, a1, b0, b1, asum, bsum;
  logic [`W3:0] min0, min1, mout;
  logic [`W3:0] t0, t1, t2, c0_nxt, c1_tmp, c1_nxt;
  logic        mreset, mdone;
  logic [1:0]  sel;
  logic        cap0, cap1, cap2;

  assign {a1, a0} = a;
  assign {b1, b0} = b;

  f33m_add u_asum (.a(a0), .b(a1), .c(asum));
  f33m_add u_bsum (.a(b0), .b(b1), .c(bsum));

  // sel is a pure function of state, so it holds for the whole sub-multiply.
  always_comb begin
    case (sel)
      2'd1:    begin min0 = a1;   min1 = b1;   end
      2'd2:    begin min0 = asum; min1 = bsum; end
      default: begin min0 = a0;   min1 = b0;   end
    endcase
  end

  f33m_mult u_mult (
    .clk  (clk),
    .reset(mreset),
    .a    (min0),
    .b    (min1),
    .c    (mout),
    .done (mdone)
  );

  f33m_sub u_c0  (.a(t0),     .b(t1), .c(c0_nxt));
  f33m_sub u_c1a (.a(t2),     .b(t0), .c(c1_tmp));
  f33m_sub u_c1b (.a(c1_tmp), .b(t1), .c(c1_nxt));

  // mdone is only looked at in WTk: in ISSk it may still be high from the
  // previous product, but the ISS edge resets the multiplier and clears it.
  always_comb begin
    state_nxt = state;
    mreset    = 1'b0;
    sel       = 2'd0;
    cap0      = 1'b0;
    cap1      = 1'b0;
    cap2      = 1'b0;
    case (state)
      ISS0: begin mreset = 1'b1; state_nxt = WT0; end
      WT0:  if (mdone) begin cap0 = 1'b1; state_nxt = ISS1; end
      ISS1: begin mreset = 1'b1; sel = 2'd1; state_nxt = WT1; end
      WT1:  begin
        sel = 2'd1;
        if (mdone) begin cap1 = 1'b1; state_nxt = ISS2; end
      end
      ISS2: begin mreset = 1'b1; sel = 2'd2; state_nxt = WT2; end
      WT2:  begin
        sel = 2'd2;
        if (mdone) begin cap2 = 1'b1; state_nxt = FIN; end
      end
      FIN:  state_nxt = DONE;
      DONE: mreset = 1'b1;
      default: state_nxt = ISS0;
    endcase
    if (reset) begin
      state_nxt = ISS0;
      mreset    = 1'b1;
      cap0      = 1'b0;
      cap1      = 1'b0;
      cap2      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state <= state_nxt;
    if (cap0) t0 <= mout;
    if (cap1) t1 <= mout;
    if (cap2) t2 <= mout;
    if (reset) begin
      c    <= '0;
      done <= 1'b0;
    end else if (state == FIN) begin
      c    <= {c1_nxt, c0_nxt};
      done <= 1'b1;
    end
  end
endmodule

// File: doc/f36m_mult.md
# f36m_mult

Sequential multiplier for GF(3^{6M}) = GF(3^{3M})[σ]/(σ²+1), the next tower level above the GF(3^{3M}) multiplier. It computes c = a·b with three Karatsuba sub-products (a0·b0, a1·b1, (a0+a1)·(b0+b1)), issued one after another to a single shared f33m_mult instance. It then combines them with f33m_add/f33m_sub. It sits downstream of f33m_mult in the pairing datapath and feeds the final-exponentiation and Miller-loop stages.

## Interface
- Parameters: none. Widths come from the shared include: `W3` is the top bit of a GF(3^{3M}) element, `W6` = 2·(`W3`+1)−1 is the top bit of a GF(3^{6M}) element.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high. Doubles as the start strobe.
- a  in  `W6`+1  operand, packed {a1,a0}, each a GF(3^{3M}) element. Value = a0 + a1·σ.
- b  in  `W6`+1  operand, packed {b1,b0}.
- c  out  `W6`+1  product, packed {c1,c0}. Registered; reset value 0.
- done  out  1  result valid. Registered; reset value 0; stays high until the next reset.

## Operation
- Protocol:
  - Caller drives a and b, then asserts reset for ≥1 cycle.
  - Computation starts on the first cycle with reset low.
  - a and b must stay stable until done=1. They are sampled continuously, not latched.
- Internal signals: one f33m_mult instance (`mreset`, `min0`, `min1`, `mout`, `mdone`) and three GF(3^{3M}) product registers t0, t1, t2.
- Operand mux by product index k:
  - k=0: (a0, b0)
  - k=1: (a1, b1)
  - k=2: (a0+a1, b0+b1), via f33m_add.
  - The mux select must hold for the whole sub-multiply; f33m_mult reads its inputs throughout.
- State machine (one-hot or encoded; one state register):
  - ISS0: mreset=1, sel=0. Next state WT0.
  - WT0: mreset=0, sel=0. On mdone=1: t0←mout, go to ISS1.
  - ISS1 / WT1: same as ISS0/WT0 with sel=1; capture t1, then go to ISS2.
  - ISS2 / WT2: same with sel=2; capture t2, then go to FIN.
  - FIN: c0←t0−t1; c1←t2−t0−t1; done←1; go to DONE.
  - DONE: hold c and done. mreset=1, so the multiplier is parked.
- Reset behaviour:
  - reset=1 forces state ISS0, done←0, c←0, mreset=1, regardless of the current state.
  - Reset mid-operation abandons the partial products; t0..t2 need not be cleared.
- Arithmetic:
  - All additions and subtractions are coefficient-wise in GF(3) via f33m_add/f33m_sub. No carries.
  - σ² = −1, which yields c0 = a0b0 − a1b1 and c1 = (a0+a1)(b0+b1) − a0b0 − a1b1.
- mdone sampling:
  - mdone is only honoured in WTk states.
  - In ISSk, a stale mdone=1 left over from the previous product must be ignored. f33m_mult clears done on the edge where its reset is sampled, so mdone is already 0 in the first WTk cycle.

## Timing
- Let Lm = number of cycles from f33m_mult reset deassertion until its done is first high.
- Per sub-product: 1 ISS cycle + Lm WT cycles. The capture happens on the edge where mdone=1 is seen in WT.
- Total latency from the first reset-low cycle to done=1 is 3·(1+Lm) + 1 cycles.
  - The FIN edge writes c and done together, so c is valid in the same cycle done first reads 1.
- Back-to-back operations: the caller asserts reset for one cycle in the cycle after done=1 was observed; a new result follows after the same latency.
- reset held high for N cycles: the block stays in ISS0 with mreset=1. The latency count starts at the first low cycle.
- No output changes between done rising and the next reset.

## Test plan
Notation: 1 is the GF(3^{3M}) one element, 0 the zero element, −1 = 2·1.
- Identity: a={0,1}, b={0,1}, reset for 1 cycle → after exactly 3·(1+Lm)+1 cycles done=1 and c={0,1}. done is 0 on every earlier cycle; c=0 before done.
- σ·σ and conjugates:
  - a={1,0}, b={1,0} → c={0,−1}.
  - a={1,1}, b={−1,1} (1+σ times 1−σ) → c={0,−1}, since 1−σ² = 2 = −1.
- Zero and general: a={x1,x0} random, b={0,0} → c={0,0}. Then 200 random (a,b) pairs vs a software GF(3^{6M}) model → exact match, with done timing checked on each.
- Reset mid-operation:
  - Start a={0,1}, b={0,1}; while in WT1, change to a={1,0}, b={1,0} and pulse reset.
  - Required: done=0 and c=0 on the cycle after the pulse; final c={0,−1}; latency counted from the second reset.
- Back-to-back and hold:
  - Three consecutive operations, each started with a 1-cycle reset after done → each result correct.
  - While done=1, held 50 extra cycles with no reset → c and done unchanged.
  - reset held 5 cycles → latency measured from deassertion.
